// File: rtl/audio_pkg.sv
// Shared types and widths for the SRAM audio streamer.
//   SAMPLE_W        : PCM sample width
//   SRAM_AW         : SRAM word-address width
//   stream_state_e  : streamer FSM states
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SRAM_AW  = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } stream_state_e;

endpackage

// File: rtl/sram_audio_streamer_fifo.sv
// sample_fifo: synchronous FIFO holding prefetched samples.
//   Clk, reset     : clock, synchronous active-high reset
//   flush          : empty the FIFO (wins over push/pop)
//   push, wdata    : write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   rdata          : head entry (show-ahead, valid when !empty)
//   count/full/empty : occupancy
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sram_audio_streamer.sv
// sram_audio_streamer: plays a PCM song image out of SRAM into the DAC path.
// Owns the SRAM control pins, walks START_ADDR..END_ADDR and keeps a small
// prefetch FIFO topped up so every advance pulse is served immediately.
//   Clk, reset        : clock, synchronous active-high reset
//   start / cont      : (re)start pulse / pause-toggle pulse
//   advance           : DAC consumed one sample
//   sram_rdata        : SRAM read data
//   SRAM_*            : word address and active-low controls
//   sample_out        : registered sample to the DAC
//   playing/paused/done, underrun_count : status
module sram_audio_streamer import audio_pkg::*; #(
  parameter logic [SRAM_AW-1:0] START_ADDR = 20'h00000,
  parameter logic [SRAM_AW-1:0] END_ADDR   = 20'hFFFFF,
  parameter int                 READ_WAIT  = 2,
  parameter int                 FIFO_DEPTH = 4,
  parameter bit                 LOOP       = 1'b0
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cont,
  input  logic                advance,
  input  logic [SAMPLE_W-1:0] sram_rdata,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                playing,
  output logic                paused,
  output logic                done,
  output logic [7:0]          underrun_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  stream_state_e       state_q, state_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic                rd_active_q, rd_active_d;
  logic [2:0]          wait_q, wait_d;
  logic                last_read_q, last_read_d;   // END_ADDR already issued+completed
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [7:0]          ur_q, ur_d;

  logic                fifo_flush, fifo_push, fifo_pop;
  logic [SAMPLE_W-1:0] fifo_rdata;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full, fifo_empty;

  logic                rd_done, issue, song_over;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (sram_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_active_d = rd_active_q;
    wait_d      = wait_q;
    last_read_d = last_read_q;
    sample_d    = sample_q;
    ur_d        = ur_q;
    fifo_flush  = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;

    // Read completes on the READ_WAIT-th edge after the one that launched it.
    rd_done   = rd_active_q && (wait_q == 3'(READ_WAIT - 1));
    song_over = last_read_q && !rd_active_q;
    // Only one read in flight, so free space is simply count < depth.
    // A cont in this cycle is about to pause, so don't launch anything.
    issue     = ((state_q == ST_FILL) || (state_q == ST_RUN)) && !cont &&
                !rd_active_q && !last_read_q && (fifo_count < CW'(FIFO_DEPTH));

    // SRAM read sequencing runs in every state; a pause only stops issue.
    if (rd_active_q) begin
      if (rd_done) begin
        fifo_push   = 1'b1;
        rd_active_d = 1'b0;
        wait_d      = '0;
        if (addr_q == END_ADDR) begin
          if (LOOP) addr_d = START_ADDR;
          else      last_read_d = 1'b1;
        end else begin
          addr_d = addr_q + SRAM_AW'(1);
        end
      end else begin
        wait_d = wait_q + 3'd1;
      end
    end else if (issue) begin
      rd_active_d = 1'b1;
      wait_d      = '0;
    end

    case (state_q)
      ST_FILL: begin
        if (cont)                         state_d = ST_PAUSED;
        else if (fifo_full || song_over)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (advance && fifo_empty && song_over) begin
          // Song exhausted: the starved pulse ends playback, not an underrun.
          state_d  = ST_DONE;
          sample_d = '0;
        end else begin
          if (advance) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              sample_d = fifo_rdata;
            end else begin
              // A same-cycle push still lands; this pulse is simply starved.
              sample_d = '0;
              if (ur_q != 8'hFF) ur_d = ur_q + 8'd1;
            end
          end
          if (cont) state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (cont) state_d = fifo_full ? ST_RUN : ST_FILL;
      end
      ST_DONE:  sample_d = '0;
      default: ;
    endcase

    // start aborts everything: drop the in-flight word and rewind.
    if (start) begin
      state_d     = ST_FILL;
      fifo_flush  = 1'b1;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;
      rd_active_d = 1'b0;
      wait_d      = '0;
      addr_d      = START_ADDR;
      last_read_d = 1'b0;
      ur_d        = '0;
      sample_d    = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= START_ADDR;
      rd_active_q <= 1'b0;
      wait_q      <= '0;
      last_read_q <= 1'b0;
      sample_q    <= '0;
      ur_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_active_q <= rd_active_d;
      wait_q      <= wait_d;
      last_read_q <= last_read_d;
      sample_q    <= sample_d;
      ur_q        <= ur_d;
    end
  end

  assign SRAM_ADDR      = addr_q;
  assign SRAM_CE_N      = ~rd_active_q;
  assign SRAM_OE_N      = ~rd_active_q;
  assign SRAM_UB_N      = ~rd_active_q;
  assign SRAM_LB_N      = ~rd_active_q;
  assign SRAM_WE_N      = 1'b1;
  assign sample_out     = sample_q;
  assign playing        = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign paused         = (state_q == ST_PAUSED);
  assign done           = (state_q == ST_DONE);
  assign underrun_count = ur_q;

endmodule

// File: tb/tb_sram_audio_streamer.sv
// Self-checking bench for sram_audio_streamer. Four instances cover the
// parameter sets: 0 = defaults, 1 = END_ADDR 5 no loop, 2 = END_ADDR 5 loop,
// 3 = READ_WAIT 7. Each has an SRAM model returning 16'h1000 + address.
module tb_sram_audio_streamer;

  logic Clk = 1'b0;
  always #10 Clk = ~Clk;

  logic        reset;
  logic        start [4];
  logic        cont  [4];
  logic        adv   [4];
  logic [15:0] rdata [4];
  logic [15:0] so    [4];
  logic [19:0] addr  [4];
  logic        ce_n [4], oe_n [4], we_n [4], ub_n [4], lb_n [4];
  logic        play [4], paus [4], dn [4];
  logic [7:0]  ur   [4];

  int checks = 0;
  int passed = 0;

  for (genvar g = 0; g < 4; g++) begin : g_sram
    assign rdata[g] = (oe_n[g] || ce_n[g]) ? 16'hBAD0 : 16'h1000 + addr[g][15:0];
  end

  sram_audio_streamer u_main (
    .Clk(Clk), .reset(reset), .start(start[0]), .cont(cont[0]), .advance(adv[0]),
    .sram_rdata(rdata[0]), .SRAM_ADDR(addr[0]), .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n[0]),
    .SRAM_WE_N(we_n[0]), .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]), .sample_out(so[0]),
    .playing(play[0]), .paused(paus[0]), .done(dn[0]), .underrun_count(ur[0]));

  sram_audio_streamer #(.START_ADDR(20'h0), .END_ADDR(20'h5), .LOOP(1'b0)) u_stop (
    .Clk(Clk), .reset(reset), .start(start[1]), .cont(cont[1]), .advance(adv[1]),
    .sram_rdata(rdata[1]), .SRAM_ADDR(addr[1]), .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n[1]),
    .SRAM_WE_N(we_n[1]), .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]), .sample_out(so[1]),
    .playing(play[1]), .paused(paus[1]), .done(dn[1]), .underrun_count(ur[1]));

  sram_audio_streamer #(.START_ADDR(20'h0), .END_ADDR(20'h5), .LOOP(1'b1)) u_loop (
    .Clk(Clk), .reset(reset), .start(start[2]), .cont(cont[2]), .advance(adv[2]),
    .sram_rdata(rdata[2]), .SRAM_ADDR(addr[2]), .SRAM_CE_N(ce_n[2]), .SRAM_OE_N(oe_n[2]),
    .SRAM_WE_N(we_n[2]), .SRAM_UB_N(ub_n[2]), .SRAM_LB_N(lb_n[2]), .sample_out(so[2]),
    .playing(play[2]), .paused(paus[2]), .done(dn[2]), .underrun_count(ur[2]));

  sram_audio_streamer #(.READ_WAIT(7)) u_slow (
    .Clk(Clk), .reset(reset), .start(start[3]), .cont(cont[3]), .advance(adv[3]),
    .sram_rdata(rdata[3]), .SRAM_ADDR(addr[3]), .SRAM_CE_N(ce_n[3]), .SRAM_OE_N(oe_n[3]),
    .SRAM_WE_N(we_n[3]), .SRAM_UB_N(ub_n[3]), .SRAM_LB_N(lb_n[3]), .sample_out(so[3]),
    .playing(play[3]), .paused(paus[3]), .done(dn[3]), .underrun_count(ur[3]));

  // One advance pulse after 'gap' idle cycles, then the expected outputs.
  typedef struct {
    int          inst;
    int          gap;
    logic [15:0] s;
    logic [7:0]  u;
    logic        d;
    logic        p;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int i, input int g, input logic [15:0] s,
                     input logic [7:0] u, input logic d, input logic p);
    vec_t v;
    v.inst = i; v.gap = g; v.s = s; v.u = u; v.d = d; v.p = p;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1; @(negedge Clk); start[i] = 1'b0;
  endtask

  task automatic pulse_cont(input int i);
    cont[i] = 1'b1; @(negedge Clk); cont[i] = 1'b0;
  endtask

  task automatic pulse_adv(input int i);
    adv[i] = 1'b1; @(negedge Clk); adv[i] = 1'b0;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int n = lo; n <= hi; n++) begin
      idle(vt[n].gap);
      pulse_adv(vt[n].inst);
      chk($sformatf("vec%0d sample", n),   so[vt[n].inst],   vt[n].s);
      chk($sformatf("vec%0d underrun", n), ur[vt[n].inst],   vt[n].u);
      chk($sformatf("vec%0d done", n),     dn[vt[n].inst],   vt[n].d);
      chk($sformatf("vec%0d playing", n),  play[vt[n].inst], vt[n].p);
    end
  endtask

  initial begin
    bit found;
    bit lowx;

    // 0..2: default instance after pause/resume
    add(0, 3, 16'h1002, 8'd0, 1'b0, 1'b1);
    add(0, 3, 16'h1003, 8'd0, 1'b0, 1'b1);
    add(0, 3, 16'h1004, 8'd0, 1'b0, 1'b1);
    // 3..12: END_ADDR=5, stop at end
    for (int k = 0; k < 6; k++) add(1, 3, 16'h1000 + 16'(k), 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) add(1, 3, 16'h0000, 8'd0, 1'b1, 1'b0);
    // 13..22: END_ADDR=5, looping
    for (int k = 0; k < 10; k++) add(2, 3, 16'h1000 + 16'(k % 6), 8'd0, 1'b0, 1'b1);
    // 23..34: READ_WAIT=7, advance every 3 cycles
    add(3, 2, 16'h1000, 8'd0, 1'b0, 1'b1);
    add(3, 2, 16'h1001, 8'd0, 1'b0, 1'b1);
    add(3, 2, 16'h1002, 8'd0, 1'b0, 1'b1);
    add(3, 2, 16'h1003, 8'd0, 1'b0, 1'b1);
    add(3, 2, 16'h1004, 8'd0, 1'b0, 1'b1);
    add(3, 2, 16'h0000, 8'd1, 1'b0, 1'b1);
    add(3, 2, 16'h1005, 8'd1, 1'b0, 1'b1);
    add(3, 2, 16'h0000, 8'd2, 1'b0, 1'b1);
    add(3, 2, 16'h0000, 8'd3, 1'b0, 1'b1);  // starved while a word lands
    add(3, 2, 16'h1006, 8'd3, 1'b0, 1'b1);
    add(3, 2, 16'h0000, 8'd4, 1'b0, 1'b1);
    add(3, 2, 16'h1007, 8'd4, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0; cont[i] = 1'b0; adv[i] = 1'b0;
    end
    reset = 1'b1;
    idle(3);
    reset = 1'b0;

    chk("rst addr",  addr[0], 20'h0);
    chk("rst ce_n",  ce_n[0], 1'b1);
    chk("rst oe_n",  oe_n[0], 1'b1);
    chk("rst we_n",  we_n[0], 1'b1);
    chk("rst ub_lb", {ub_n[0], lb_n[0]}, 2'b11);
    chk("rst sample", so[0], 16'h0);
    chk("rst flags", {play[0], paus[0], dn[0]}, 3'b000);
    chk("rst ur",    ur[0], 8'h0);

    // Start: reads launch one edge later, one per 3 edges until 4 are held.
    pulse_start(0);
    chk("start oe_n", oe_n[0], 1'b1);
    chk("start playing", play[0], 1'b1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      lowx = (k <= 11) && ((k - 1) % 3 != 2);
      chk($sformatf("fill oe_n e%0d", k), oe_n[0], !lowx);
      chk($sformatf("fill ce_n e%0d", k), ce_n[0], !lowx);
      if (lowx) chk($sformatf("fill addr e%0d", k), addr[0], 20'((k - 1) / 3));
    end
    chk("fill we_n", we_n[0], 1'b1);

    // Pause while a read is in flight.
    pulse_adv(0);
    chk("first sample", so[0], 16'h1000);
    idle(1);
    chk("refill oe_n", oe_n[0], 1'b0);
    chk("refill addr", addr[0], 20'h4);
    pulse_cont(0);
    chk("pause flags", {play[0], paus[0]}, 2'b01);
    chk("pause inflight oe_n", oe_n[0], 1'b0);
    idle(1);
    chk("pause read done oe_n", oe_n[0], 1'b1);
    pulse_adv(0);
    chk("pause adv sample held", so[0], 16'h1000);
    chk("pause adv no underrun", ur[0], 8'h0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk($sformatf("pause no read %0d", k), oe_n[0], 1'b1);
    end
    pulse_cont(0);
    chk("resume flags", {play[0], paus[0]}, 2'b10);
    pulse_adv(0);
    chk("resume sample", so[0], 16'h1001);
    idle(1);
    chk("resume oe_n", oe_n[0], 1'b0);
    chk("resume addr", addr[0], 20'h5);
    apply(0, 2);

    // start+cont together while address 0x40 is being read.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      adv[0] = (i % 4 == 0);
      @(negedge Clk);
      if (addr[0] == 20'h40 && !oe_n[0]) found = 1'b1;
    end
    adv[0] = 1'b0;
    chk("reach addr 0x40", found, 1'b1);
    start[0] = 1'b1; cont[0] = 1'b1;
    @(negedge Clk);
    start[0] = 1'b0; cont[0] = 1'b0;
    chk("abort flags", {play[0], paus[0]}, 2'b10);
    chk("abort oe_n", oe_n[0], 1'b1);
    chk("abort addr", addr[0], 20'h0);
    idle(1);
    chk("abort reread oe_n", oe_n[0], 1'b0);
    chk("abort reread addr", addr[0], 20'h0);
    idle(14);
    pulse_adv(0);
    chk("abort sample0", so[0], 16'h1000);
    idle(3);
    pulse_adv(0);
    chk("abort sample1", so[0], 16'h1001);

    // End of song without looping, then restart from DONE.
    pulse_start(1);
    idle(15);
    apply(3, 12);
    chk("done no read", oe_n[1], 1'b1);
    pulse_start(1);
    chk("restart flags", {play[1], dn[1]}, 2'b10);
    chk("restart sample", so[1], 16'h0);

    // Looping song.
    pulse_start(2);
    idle(15);
    apply(13, 22);

    // Slow SRAM: starved pulses, then saturation.
    pulse_start(3);
    idle(38);
    apply(23, 34);
    adv[3] = 1'b1;
    idle(400);
    adv[3] = 1'b0;
    chk("ur saturated", ur[3], 8'hFF);
    pulse_adv(3);
    chk("ur stays saturated", ur[3], 8'hFF);

    // Reset in the middle of a read.
    pulse_adv(0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!oe_n[0]) found = 1'b1;
      else @(negedge Clk);
    end
    chk("read before reset", found, 1'b1);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    chk("midrd rst pins", {ce_n[0], oe_n[0], we_n[0], ub_n[0], lb_n[0]}, 5'b11111);
    chk("midrd rst sample", so[0], 16'h0);
    chk("midrd rst flags", {play[0], paus[0], dn[0]}, 3'b000);
    chk("midrd rst addr", addr[0], 20'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
